// File: rtl/mul_arbiter_if.sv
// Request/response bundle for mul_arbiter: REQS valid/ready request ports
// with packed operands, one shared response channel and a busy flag.
interface mul_arbiter_if #(
    parameter int N    = 4,
    parameter int REQS = 4
);
    localparam int IDW = (REQS > 1) ? $clog2(REQS) : 1;

    logic [REQS-1:0]   req_valid;
    logic [REQS-1:0]   req_ready;
    logic [REQS*N-1:0] req_x;
    logic [REQS*N-1:0] req_y;
    logic              resp_valid;
    logic              resp_ready;
    logic [IDW-1:0]    resp_id;
    logic [2*N-1:0]    resp_p;
    logic              busy;

    // Requesters and result consumer
    modport master (
        output req_valid, req_x, req_y, resp_ready,
        input  req_ready, resp_valid, resp_id, resp_p, busy
    );

    // The arbiter itself
    modport slave (
        input  req_valid, req_x, req_y, resp_ready,
        output req_ready, resp_valid, resp_id, resp_p, busy
    );
endinterface

// File: rtl/mul_arbiter.sv
// Round-robin arbiter sharing one combinational array multiplier among REQS
// requesters. Operands are registered before reaching the multiplier, the
// product is captured after SETTLE cycles and returned with the owner's id.

// Unsigned N x N -> 2N combinational multiplier.
module mul #(
    parameter int N = 4
) (
    input  logic [N-1:0]   i_a,
    input  logic [N-1:0]   i_b,
    output logic [2*N-1:0] o_p
);
    assign o_p = {{N{1'b0}}, i_a} * {{N{1'b0}}, i_b};
endmodule

module mul_arbiter #(
    parameter int N      = 4,
    parameter int REQS   = 4,
    parameter int SETTLE = 1
) (
    input logic           clk,
    input logic           rst,
    mul_arbiter_if.slave  bus
);
    localparam int IDW = (REQS > 1) ? $clog2(REQS) : 1;
    localparam int CW  = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]      r_state;
    logic [IDW-1:0]  r_ptr;
    logic [IDW-1:0]  r_id;
    logic [N-1:0]    r_x;
    logic [N-1:0]    r_y;
    logic [CW-1:0]   r_cnt;
    logic [2*N-1:0]  r_resp_p;
    logic [IDW-1:0]  r_resp_id;

    logic            w_found;
    logic [IDW-1:0]  w_grant;
    logic [N-1:0]    w_sel_x;
    logic [N-1:0]    w_sel_y;
    logic [REQS-1:0] w_onehot;
    logic            w_accept;
    logic [IDW-1:0]  w_ptr_next;
    logic [2*N-1:0]  w_prod;

    // Round-robin pick: first pass covers ptr..REQS-1, second pass wraps to 0..ptr-1
    always_comb begin
        w_found  = 1'b0;
        w_grant  = '0;
        w_sel_x  = '0;
        w_sel_y  = '0;
        w_onehot = '0;
        for (int unsigned r = 0; r < REQS; r++) begin
            if (!w_found && bus.req_valid[r] && (r >= 32'(r_ptr))) begin
                w_found     = 1'b1;
                w_grant     = IDW'(r);
                w_sel_x     = bus.req_x[r*N +: N];
                w_sel_y     = bus.req_y[r*N +: N];
                w_onehot[r] = 1'b1;
            end
        end
        for (int unsigned r = 0; r < REQS; r++) begin
            if (!w_found && bus.req_valid[r]) begin
                w_found     = 1'b1;
                w_grant     = IDW'(r);
                w_sel_x     = bus.req_x[r*N +: N];
                w_sel_y     = bus.req_y[r*N +: N];
                w_onehot[r] = 1'b1;
            end
        end
    end

    assign w_accept   = (r_state == S_IDLE) && w_found;
    assign w_ptr_next = (r_id == IDW'(REQS - 1)) ? '0 : r_id + IDW'(1);

    // Ready is gated by rst so it drops in the same cycle reset is raised
    assign bus.req_ready  = ((r_state == S_IDLE) && !rst) ? w_onehot : '0;
    assign bus.resp_valid = (r_state == S_RESP);
    assign bus.busy       = (r_state != S_IDLE);
    assign bus.resp_p     = r_resp_p;
    assign bus.resp_id    = r_resp_id;

    // The shared multiplier only ever sees the registered operands
    mul #(.N(N)) u_mul (
        .i_a (r_x),
        .i_b (r_y),
        .o_p (w_prod)
    );

    // Control FSM: IDLE -> EXEC on accept, EXEC -> RESP when settled, RESP -> IDLE on consume
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: if (w_accept) r_state <= S_EXEC;
                S_EXEC: if (r_cnt == '0) r_state <= S_RESP;
                S_RESP: if (bus.resp_ready) r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Operand, owner and settle-counter capture on the accept edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x   <= '0;
            r_y   <= '0;
            r_id  <= '0;
            r_cnt <= '0;
        end else if (w_accept) begin
            r_x   <= w_sel_x;
            r_y   <= w_sel_y;
            r_id  <= w_grant;
            r_cnt <= CW'(SETTLE - 1);
        end else if ((r_state == S_EXEC) && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CW'(1);
        end
    end

    // Response registers load once the array has settled and hold through RESP
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_resp_p  <= '0;
            r_resp_id <= '0;
        end else if ((r_state == S_EXEC) && (r_cnt == '0)) begin
            r_resp_p  <= w_prod;
            r_resp_id <= r_id;
        end
    end

    // Round-robin pointer moves past the owner once its result is consumed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
        end else if ((r_state == S_RESP) && bus.resp_ready) begin
            r_ptr <= w_ptr_next;
        end
    end
endmodule

// File: tb/tb_mul_arbiter.sv
// Self-checking bench for mul_arbiter (N=4, REQS=4, SETTLE=1): a transaction
// level model checked every cycle, directed scenarios with literal
// expectations, an exhaustive operand sweep and a randomized phase.
module tb_mul_arbiter;
    localparam int N      = 4;
    localparam int REQS   = 4;
    localparam int SETTLE = 1;

    logic clk;
    logic rst;
    int   cyc;
    int   n_checks;
    int   n_fail;
    bit   mon_en;

    logic [REQS-1:0] hs_q;
    int              g_id[$];
    int              g_cyc[$];

    // Model of the arbiter as a sequence of transactions
    int   m_ptr;
    bit   m_busy;
    bit   m_respv;
    int   m_wait;
    int   m_id;
    int   m_prod;
    int   m_rp;
    int   m_rid;

    mul_arbiter_if #(.N(N), .REQS(REQS)) bus ();

    mul_arbiter #(.N(N), .REQS(REQS), .SETTLE(SETTLE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle counter for grant spacing
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int rr_pick(input logic [REQS-1:0] v, input int p);
        int r;
        for (int k = 0; k < REQS; k++) begin
            r = (p + k) % REQS;
            if (v[r]) return r;
        end
        return -1;
    endfunction

    // Handshake sampler and DUT grant log
    always @(negedge clk) begin
        hs_q = bus.req_valid & bus.req_ready;
        for (int r = 0; r < REQS; r++) begin
            if (hs_q[r]) begin
                g_id.push_back(r);
                g_cyc.push_back(cyc);
            end
        end
    end

    // Per-cycle comparison against the model, then advance the model
    always @(negedge clk) begin
        int pick;
        logic [REQS-1:0] exp_ready;
        if (mon_en) begin
            if (rst) begin
                chk("rst_ready", 32'(bus.req_ready), 32'd0);
                chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
                chk("rst_busy", 32'(bus.busy), 32'd0);
                chk("rst_resp_p", 32'(bus.resp_p), 32'd0);
                chk("rst_resp_id", 32'(bus.resp_id), 32'd0);
                m_ptr = 0; m_busy = 0; m_respv = 0; m_rp = 0; m_rid = 0;
            end else begin
                pick = m_busy ? -1 : rr_pick(bus.req_valid, m_ptr);
                exp_ready = (pick >= 0) ? (REQS'(1) << pick) : '0;
                chk("mdl_ready", 32'(bus.req_ready), 32'(exp_ready));
                chk("mdl_resp_valid", 32'(bus.resp_valid), 32'(m_respv));
                chk("mdl_busy", 32'(bus.busy), 32'(m_busy));
                chk("mdl_resp_p", 32'(bus.resp_p), 32'(m_rp));
                chk("mdl_resp_id", 32'(bus.resp_id), 32'(m_rid));
                if (!m_busy) begin
                    if (pick >= 0) begin
                        m_busy = 1;
                        m_id   = pick;
                        m_prod = int'(bus.req_x[pick*N +: N]) * int'(bus.req_y[pick*N +: N]);
                        m_wait = SETTLE;
                    end
                end else if (!m_respv) begin
                    m_wait--;
                    if (m_wait == 0) begin
                        m_respv = 1;
                        m_rp    = m_prod;
                        m_rid   = m_id;
                    end
                end else if (bus.resp_ready) begin
                    m_respv = 0;
                    m_busy  = 0;
                    m_ptr   = (m_id + 1) % REQS;
                end
            end
        end
    end

    // Advance one cycle; requesters drop valid once their handshake completed
    task automatic nx();
        @(posedge clk);
        #1;
        bus.req_valid = bus.req_valid & ~hs_q;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.req_valid = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic set_op(input int r, input int x, input int y);
        bus.req_x[r*N +: N] = N'(x);
        bus.req_y[r*N +: N] = N'(y);
        bus.req_valid[r]    = 1'b1;
    endtask

    task automatic wait_grants(input int n, input string nm);
        int b = 0;
        while (g_id.size() < n && b < 40) begin
            nx();
            b++;
        end
        if (g_id.size() < n) chk({nm, "_timeout"}, 32'(g_id.size()), 32'(n));
    endtask

    task automatic drain(input string nm);
        int b = 0;
        while ((bus.req_valid != '0 || bus.busy) && b < 200) begin
            nx();
            b++;
        end
        if (bus.req_valid != '0 || bus.busy) chk({nm, "_drain_timeout"}, 32'(bus.busy), 32'd0);
    endtask

    task automatic wait_resp(input string nm);
        int b = 0;
        while (!bus.resp_valid && b < 10) begin
            nx();
            b++;
        end
        if (!bus.resp_valid) chk({nm, "_resp_timeout"}, 32'(bus.resp_valid), 32'd1);
    endtask

    initial begin
        int exp_order[5];
        bit reraised;
        int b;
        bit got;
        logic [2*N-1:0] pv;

        n_checks = 0; n_fail = 0; mon_en = 0; cyc = 0; hs_q = '0;
        m_ptr = 0; m_busy = 0; m_respv = 0; m_rp = 0; m_rid = 0; m_wait = 0; m_id = 0; m_prod = 0;
        rst = 1'b1;
        bus.req_valid = '0; bus.req_x = '0; bus.req_y = '0; bus.resp_ready = 1'b1;
        do_reset();
        mon_en = 1;

        // Single request from requester 2, 15*15
        set_op(2, 15, 15);
        @(negedge clk); chk("s1_ready_c0", 32'(bus.req_ready), 32'b0100);
        nx();
        @(negedge clk); chk("s1_busy_c1", 32'(bus.busy), 32'd1);
        chk("s1_rv_c1", 32'(bus.resp_valid), 32'd0);
        nx();
        @(negedge clk); chk("s1_rv_c2", 32'(bus.resp_valid), 32'd1);
        chk("s1_p_c2", 32'(bus.resp_p), 32'hE1);
        chk("s1_id_c2", 32'(bus.resp_id), 32'd2);
        chk("s1_busy_c2", 32'(bus.busy), 32'd1);
        nx();
        @(negedge clk); chk("s1_busy_c3", 32'(bus.busy), 32'd0);
        chk("s1_rv_c3", 32'(bus.resp_valid), 32'd0);

        // ptr is now 3: requesters 3 and 0 only
        g_id.delete(); g_cyc.delete();
        set_op(0, 4, 5); set_op(3, 6, 7);
        wait_grants(2, "s3");
        chk("s3_first", 32'((g_id.size() > 0) ? g_id[0] : 99), 32'd3);
        chk("s3_second", 32'((g_id.size() > 1) ? g_id[1] : 99), 32'd0);
        drain("s3a");
        g_id.delete(); g_cyc.delete();
        set_op(0, 1, 2); set_op(1, 3, 3);
        wait_grants(1, "s3b");
        chk("s3_ptr_wrapped_to_1", 32'((g_id.size() > 0) ? g_id[0] : 99), 32'd1);
        drain("s3b");

        // All four requesters from ptr=0, requester 0 re-requests
        do_reset();
        g_id.delete(); g_cyc.delete();
        for (int r = 0; r < REQS; r++) set_op(r, r + 1, r + 2);
        reraised = 0;
        b = 0;
        while (g_id.size() < 5 && b < 40) begin
            nx();
            if (!reraised && hs_q[0]) begin
                set_op(0, 9, 9);
                reraised = 1;
            end
            b++;
        end
        exp_order[0] = 0; exp_order[1] = 1; exp_order[2] = 2; exp_order[3] = 3; exp_order[4] = 0;
        for (int i = 0; i < 5; i++)
            chk($sformatf("s2_order%0d", i), 32'((g_id.size() > i) ? g_id[i] : 99), 32'(exp_order[i]));
        for (int i = 0; i < 4; i++)
            chk($sformatf("s2_gap%0d", i), 32'((g_cyc.size() > i + 1) ? g_cyc[i+1] - g_cyc[i] : 0), 32'd3);
        drain("s2");

        // Response back-pressure for 5 cycles
        bus.resp_ready = 1'b0;
        set_op(1, 7, 9);
        wait_resp("s4");
        set_op(0, 2, 3); set_op(2, 5, 5); set_op(3, 4, 4);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("s4_rv%0d", i), 32'(bus.resp_valid), 32'd1);
            chk($sformatf("s4_p%0d", i), 32'(bus.resp_p), 32'd63);
            chk($sformatf("s4_id%0d", i), 32'(bus.resp_id), 32'd1);
            chk($sformatf("s4_ready%0d", i), 32'(bus.req_ready), 32'd0);
            nx();
        end
        bus.resp_ready = 1'b1;
        @(negedge clk); chk("s4_rv_c6", 32'(bus.resp_valid), 32'd1);
        nx();
        @(negedge clk); chk("s4_idle_busy", 32'(bus.busy), 32'd0);
        chk("s4_next_grant", 32'(bus.req_ready), 32'b0100);
        drain("s4");

        // Reset while EXEC
        set_op(3, 5, 6);
        @(negedge clk); chk("s5_ready", 32'(bus.req_ready), 32'b1000);
        nx();
        chk("s5_in_exec", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        bus.req_valid = '0;
        set_op(1, 3, 4); set_op(2, 2, 2);
        #1;
        chk("s5_rv0", 32'(bus.resp_valid), 32'd0);
        chk("s5_ready0", 32'(bus.req_ready), 32'd0);
        chk("s5_busy0", 32'(bus.busy), 32'd0);
        chk("s5_p0", 32'(bus.resp_p), 32'd0);
        chk("s5_id0", 32'(bus.resp_id), 32'd0);
        nx();
        rst = 1'b0;
        @(negedge clk); chk("s5_post_grant", 32'(bus.req_ready), 32'b0010);
        wait_resp("s5");
        chk("s5_resp_id", 32'(bus.resp_id), 32'd1);
        chk("s5_resp_p", 32'(bus.resp_p), 32'd12);
        drain("s5");

        // Exhaustive operand sweep through requester 1
        for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
                set_op(1, x, y);
                got = 0;
                pv = '0;
                for (int c = 0; c < 10 && !got; c++) begin
                    @(negedge clk);
                    if (bus.resp_valid && bus.resp_ready) begin
                        got = 1;
                        pv  = bus.resp_p;
                    end
                    nx();
                end
                if (!got) chk($sformatf("s6_timeout_%0d_%0d", x, y), 32'd0, 32'd1);
                else chk($sformatf("s6_p_%0d_%0d", x, y), 32'(pv), 32'(x * y));
            end
        end

        // Randomized traffic with random back-pressure
        for (int i = 0; i < 1500; i++) begin
            nx();
            for (int r = 0; r < REQS; r++) begin
                if (!bus.req_valid[r] && $urandom_range(0, 2) == 0)
                    set_op(r, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
            end
            bus.resp_ready = ($urandom_range(0, 3) != 0);
        end
        bus.resp_ready = 1'b1;
        drain("rnd");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, failures=%0d", n_fail);
        $fatal(1);
    end
endmodule

// File: doc/mul_arbiter.md
# mul_arbiter

Shares one combinational `mul` array multiplier among REQS requesters. Each requester has its own valid/ready request port. A round-robin grant selects one request at a time. The block registers the operands, waits SETTLE cycles for the array to settle, then returns the 2N-bit product tagged with the requester id on a shared response channel. It sits between the operand-producing units and the single `mul` instance, so `mul` never sees unregistered or multi-driven operands.

## Interface
- N, 4: operand width passed to the `mul` instance; N >= 2.
- REQS, 4: number of requesters; REQS >= 2, not required to be a power of two.
- SETTLE, 1: number of EXEC cycles between operand capture and result capture; SETTLE >= 1.
- IDW, derived: width of `resp_id`, equal to max(1, clog2(REQS)).

- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  REQS  bit r means requester r has a request pending.
- req_ready  out  REQS  bit r means requester r is accepted this cycle.
- req_x  in  REQS*N  operand x for requester r, in bits [r*N +: N].
- req_y  in  REQS*N  operand y for requester r, in bits [r*N +: N].
- resp_valid  out  1  a result is presented on the response channel.
- resp_ready  in  1  the consumer accepts the result.
- resp_id  out  IDW  index of the requester that owns the result.
- resp_p  out  2N  unsigned product x*y.
- busy  out  1  high whenever the state is not IDLE.

## Operation
- FSM states: IDLE, EXEC, RESP. Reset state is IDLE.
- The round-robin pointer `ptr` resets to 0.
- IDLE, arbitration:
  - The grant g is the first r with req_valid[r]=1, scanning ptr, ptr+1, …, REQS-1, 0, … and wrapping modulo REQS.
  - req_ready[g]=1 combinationally in that cycle; all other ready bits are 0.
  - If no req_valid bit is set, no ready is asserted and the FSM stays in IDLE.
- A handshake completes when req_valid[g]=1 and req_ready[g]=1 at the clock edge. At that edge:
  - x_reg takes req_x[g], y_reg takes req_y[g], id_reg takes g.
  - The cycle counter loads SETTLE-1 and the FSM goes to EXEC.
- EXEC:
  - `mul` is driven only from x_reg and y_reg.
  - The counter decrements each cycle.
  - In the cycle where the counter is 0: resp_p takes the `mul` output, resp_id takes id_reg, and the FSM goes to RESP.
- RESP:
  - resp_valid=1.
  - resp_p and resp_id stay stable until resp_ready=1.
  - On the resp_ready edge: resp_valid drops, ptr becomes (id_reg+1) mod REQS, and the FSM goes to IDLE.
- req_ready is 0 in EXEC and RESP. At most one operation is in flight.
- Requesters hold req_valid, req_x and req_y stable until they receive ready. The block's behaviour for a request withdrawn before ready is: no grant to that requester.
- Arithmetic: the product is unsigned and exact in 2N bits, with no truncation or overflow. 0 * y = 0, and (2^N-1)^2 = 2^(2N) - 2^(N+1) + 1.
- Reset asserted in any state, at any time:
  - resp_valid, req_ready, busy, resp_p and resp_id go to 0 immediately.
  - ptr goes to 0 and the FSM to IDLE.
  - An in-flight operation is discarded and no response is produced for it.

## Timing
- Accept edge at the end of cycle k. EXEC occupies cycles k+1 … k+SETTLE. resp_valid is first high in cycle k+SETTLE+1.
- Minimum issue interval is SETTLE+2 cycles, reached when resp_ready=1:
  - the response handshake completes at the end of cycle k+SETTLE+1;
  - IDLE in cycle k+SETTLE+2 can accept the next request.
- Reset values: resp_valid=0, resp_p=0, resp_id=0, req_ready=0, busy=0.
- req_ready is combinational from req_valid and ptr in IDLE. resp_* and busy are registered or state-decoded, with no combinational path from resp_ready.

## Test plan
All scenarios use N=4, REQS=4, SETTLE=1.
- Single request from requester 2 with x=15, y=15, accepted in cycle 0 -> resp_valid in cycle 2, resp_p=225 (8'hE1), resp_id=2, busy high in cycles 1–2.
- All four requesters valid with ptr=0 and resp_ready held at 1 -> grants occur in order 0,1,2,3, each 3 cycles apart. Requester 0 re-requests after its grant and is served only after requester 3.
- Only requesters 3 and 0 valid with ptr=3 -> grant 3 then 0; ptr wraps to 0, then to 1.
- resp_ready held low for 5 cycles in RESP -> resp_valid, resp_p and resp_id stay stable, req_ready=4'b0000 throughout, and the handshake on cycle 6 returns the FSM to IDLE.
- rst pulsed during EXEC -> all outputs are 0 within the same cycle, no response is produced for the discarded operation, and the next grant goes to the lowest valid requester starting from 0.
- All 256 (x,y) pairs through requester 1, including x=0 and y=0 -> every resp_p equals x*y.
